paddle_ctrl: RTL and testbench
==============================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of player channels (1..4).
REQ-002 SHALL have parameter STEP_SLOW, default 4: digital step per frame, slow.
REQ-003 SHALL have parameter STEP_FAST, default 8: digital step per frame, fast.
REQ-004 SHALL have parameter CENTER, default 114: position value after reset.
REQ-005 SHALL have parameter ACCEL_FRAMES, default 16: frames a direction is held before fast step.
REQ-006 SHALL have these ports:
- clk_sys  in  1  system clock; one clock only.
- reset_n  in  1  reset, synchronous, active-low.
- hsync  in  1  line sync from the game core.
- vsync  in  1  frame sync from the game core.
- pad_en_n  in  1  active-low pad-window clear from the game core.
- sel  in  max(1,$clog2(NUM_CH))  active channel (player select).
- mode  in  2*NUM_CH  per-channel source: 0 digital, 1 X, 2 Y, 3 paddle.
- invert  in  NUM_CH  per-channel invert.
- speed  in  1  1 = force fast step.
- btn_left, btn_right  in  NUM_CH each  digital direction.
- analog_x, analog_y  in  8*NUM_CH each  signed stick axes.
- paddle  in  8*NUM_CH  unsigned paddle value.
- pos  out  8*NUM_CH  effective per-channel position.
- pad_out  out  1  pot-emulation output to the game core.

Function
REQ-007 SHALL detect hsync and vsync rising edges using registered previous values.
REQ-008 On a vsync rising edge, digital position of channel sel SHALL: right only -> subtract step, saturating at 0; left only -> add step, saturating at 255; both or neither -> hold.
REQ-009 Digital positions of unselected channels SHALL hold.
REQ-010 Analog X and Y SHALL be converted as {~v[7], v[6:0]}.
REQ-011 Effective position SHALL be: mode 0 -> digital reg; modes 1/2/3 -> converted X / converted Y / paddle, output bitwise-inverted when invert=0 and passed through when invert=1.
REQ-012 A single 8-bit line counter SHALL clear to 0 on every cycle pad_en_n=0, otherwise increment on each hsync rising edge, saturating at 255 (no wrap).
REQ-013 pad_out SHALL be registered: (counter < pos[sel]), one clk_sys cycle after the counter update.
REQ-014 A change of sel SHALL take effect in the next pad_out compare.
REQ-015 Step per frame SHALL be STEP_FAST when speed=1, else as given by the acceleration state (REQ-020).

Reset
REQ-016 While reset_n=0 at a clk_sys edge: all digital positions <= CENTER, counter <= 0, pad_out <= 0, edge registers <= 0, accel state <= IDLE.
REQ-017 Reset asserted mid-frame SHALL abandon any in-progress count; the first vsync edge after release SHALL apply a normal update.

Configuration
REQ-018 Macro PADDLE_CTRL_ACCEL_EN SHALL compile in the acceleration FSM.
REQ-019 Without PADDLE_CTRL_ACCEL_EN: step = speed ? STEP_FAST : STEP_SLOW; no FSM logic present.
REQ-020 With PADDLE_CTRL_ACCEL_EN: states IDLE, HOLD, FAST, evaluated at each vsync edge.
- IDLE -> HOLD when exactly one direction is pressed; frame counter <= 1.
- HOLD increments the frame counter each frame while the same direction is held; -> FAST when it reaches ACCEL_FRAMES.
- Any release, both pressed, reversal, or sel change -> IDLE.
- Step: STEP_SLOW in IDLE/HOLD, STEP_FAST in FAST.

Structure
REQ-021 Shared package paddle_pkg SHALL hold the mode encoding (MODE_DIGITAL, MODE_X, MODE_Y, MODE_PADDLE), the accel state enum and the default CENTER value.
REQ-022 The acceleration FSM SHALL be sub-module paddle_accel, instantiated only under PADDLE_CTRL_ACCEL_EN.

Verification
REQ-023 Reset, NUM_CH=2, mode 0 -> pos = {114,114}, pad_out 0; pad_en_n low, then 114 hsync edges -> pad_out 1 through count 113, 0 from count 114.
REQ-024 sel=0, btn_right held 30 frames, speed=1 -> ch0 pos 114->106->...->2->0, then held at 0; ch1 stays 114.
REQ-025 Both buttons pressed for 5 frames -> pos unchanged; left only from 250, step 8 -> 255 (saturated).
REQ-026 mode 1, analog_x=8'h80, invert=0 -> pos=8'hFF; invert=1 -> 8'h00; analog_x=8'h7F, invert=1 -> 8'hFF.
REQ-027 With ACCEL_EN, speed=0, left held 20 frames from 114 -> 15 steps of 4, then 5 steps of 8 (114 -> 174 -> 214); release 1 frame -> next step back to 4.
REQ-028 pad_en_n held high for 300 hsync edges -> counter stops at 255, pad_out 0 for pos=255.

Source files
------------

// File: rtl/paddle_pkg.sv
// Shared encodings for the paddle controller: source-mode codes, accel states, reset centre.
package paddle_pkg;

    localparam int CENTER_DEFAULT = 114;

    typedef enum logic [1:0] {
        MODE_DIGITAL = 2'd0,
        MODE_X       = 2'd1,
        MODE_Y       = 2'd2,
        MODE_PADDLE  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,
        ACC_HOLD = 2'd1,
        ACC_FAST = 2'd2
    } accel_state_e;

    // Signed stick axis to unsigned 0..255, centre 0 -> 128.
    function automatic logic [7:0] axis_to_u8(input logic [7:0] v);
        return {~v[7], v[6:0]};
    endfunction

endpackage

// File: rtl/paddle_accel.sv
// Hold-to-accelerate FSM for the selected channel's digital direction, advanced once per frame.
// Instantiated by paddle_ctrl only when PADDLE_CTRL_ACCEL_EN is defined.
module paddle_accel
    import paddle_pkg::*;
#(
    parameter int SEL_W        = 1,
    parameter int ACCEL_FRAMES = 16
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             frame_tick,
    input  logic             left,
    input  logic             right,
    input  logic [SEL_W-1:0] sel,
    output logic             fast
);

    localparam logic [15:0] LAST_SLOW = 16'(ACCEL_FRAMES - 1);

    accel_state_e     state;
    logic [15:0]      frames;
    logic             dir_q;
    logic [SEL_W-1:0] sel_q;
    logic             one_dir;
    logic             same;

    assign one_dir = left ^ right;
    assign same    = one_dir && (left == dir_q) && (sel == sel_q);

    // The frame that completes the hold count already moves at the fast step.
    assign fast = same && ((state == ACC_FAST) ||
                           (state == ACC_HOLD && frames >= LAST_SLOW));

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state  <= ACC_IDLE;
            frames <= '0;
            dir_q  <= 1'b0;
            sel_q  <= '0;
        end else if (frame_tick) begin
            dir_q <= left;
            sel_q <= sel;
            case (state)
                ACC_IDLE: begin
                    if (one_dir) begin
                        state  <= ACC_HOLD;
                        frames <= 16'd1;
                    end
                end
                ACC_HOLD: begin
                    if (same) begin
                        frames <= frames + 16'd1;
                        if (frames >= LAST_SLOW)
                            state <= ACC_FAST;
                    end else begin
                        state <= ACC_IDLE;
                    end
                end
                ACC_FAST: begin
                    if (!same)
                        state <= ACC_IDLE;
                end
                default: state <= ACC_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Multi-channel paddle/pot emulator: digital, stick or paddle sources feed a per-line pot compare.
// Define PADDLE_CTRL_ACCEL_EN to add hold-to-accelerate on the digital step.
module paddle_ctrl
    import paddle_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int STEP_SLOW    = 4,
    parameter int STEP_FAST    = 8,
    parameter int CENTER       = CENTER_DEFAULT,
    parameter int ACCEL_FRAMES = 16,
    localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic                  pad_en_n,
    input  logic [SEL_W-1:0]      sel,
    input  logic [2*NUM_CH-1:0]   mode,
    input  logic [NUM_CH-1:0]     invert,
    input  logic                  speed,
    input  logic [NUM_CH-1:0]     btn_left,
    input  logic [NUM_CH-1:0]     btn_right,
    input  logic [8*NUM_CH-1:0]   analog_x,
    input  logic [8*NUM_CH-1:0]   analog_y,
    input  logic [8*NUM_CH-1:0]   paddle,
    output logic [8*NUM_CH-1:0]   pos,
    output logic                  pad_out
);

    localparam logic [7:0] SLOW8   = 8'(STEP_SLOW);
    localparam logic [7:0] FAST8   = 8'(STEP_FAST);
    localparam logic [7:0] CENTER8 = 8'(CENTER);

    logic                   hs_q, vs_q, hs_rise, vs_rise;
    logic [NUM_CH-1:0][7:0] dig;
    logic [NUM_CH-1:0][7:0] eff;
    logic [7:0]             line_cnt;
    logic [7:0]             step;
    logic [7:0]             cur, pos_sel, dig_next;
    logic [8:0]             sum;
    logic                   sel_ok, l_sel, r_sel, accel_fast;

    assign hs_rise = hsync & ~hs_q;
    assign vs_rise = vsync & ~vs_q;
    assign sel_ok  = 32'(sel) < NUM_CH;
    assign l_sel   = sel_ok & btn_left[sel];
    assign r_sel   = sel_ok & btn_right[sel];

`ifdef PADDLE_CTRL_ACCEL_EN
    paddle_accel #(.SEL_W(SEL_W), .ACCEL_FRAMES(ACCEL_FRAMES)) u_accel (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .frame_tick (vs_rise),
        .left       (l_sel),
        .right      (r_sel),
        .sel        (sel),
        .fast       (accel_fast)
    );
`else
    assign accel_fast = 1'b0;
`endif

    assign step = (speed | accel_fast) ? FAST8 : SLOW8;

    // Right moves toward 0, left toward 255, both clamp instead of wrapping.
    always_comb begin
        cur      = sel_ok ? dig[sel] : 8'd0;
        sum      = {1'b0, cur} + {1'b0, step};
        dig_next = cur;
        if (r_sel && !l_sel)
            dig_next = (cur < step) ? 8'd0 : cur - step;
        else if (l_sel && !r_sel)
            dig_next = sum[8] ? 8'hFF : sum[7:0];
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mode_e      m;
        logic [7:0] raw;
        assign m   = mode_e'(mode[2*c +: 2]);
        assign raw = (m == MODE_X) ? axis_to_u8(analog_x[8*c +: 8]) :
                     (m == MODE_Y) ? axis_to_u8(analog_y[8*c +: 8]) :
                                     paddle[8*c +: 8];
        // Analog sources are inverted unless invert is set.
        assign eff[c] = (m == MODE_DIGITAL) ? dig[c] : (invert[c] ? raw : ~raw);
    end

    assign pos     = eff;
    assign pos_sel = sel_ok ? eff[sel] : 8'd0;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            line_cnt <= '0;
            pad_out  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                dig[c] <= CENTER8;
        end else begin
            hs_q <= hsync;
            vs_q <= vsync;
            if (!pad_en_n)
                line_cnt <= '0;
            else if (hs_rise && line_cnt != 8'hFF)
                line_cnt <= line_cnt + 8'd1;
            pad_out <= (line_cnt < pos_sel);
            if (vs_rise && sel_ok)
                dig[sel] <= dig_next;
        end
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Randomised self-checking bench for paddle_ctrl against a frame/line-level behavioural model.
module tb_paddle_ctrl;

    localparam int NUM_CH = 2, STEP_SLOW = 4, STEP_FAST = 8, CENTER = 114, ACCEL_FRAMES = 16;

    logic                 clk_sys = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 hsync = 1'b0, vsync = 1'b0, pad_en_n = 1'b1;
    logic [0:0]           sel = '0;
    logic [2*NUM_CH-1:0]  mode = '0;
    logic [NUM_CH-1:0]    invert = '0;
    logic                 speed = 1'b0;
    logic [NUM_CH-1:0]    btn_left = '0, btn_right = '0;
    logic [8*NUM_CH-1:0]  analog_x = '0, analog_y = '0, paddle = '0;
    logic [8*NUM_CH-1:0]  pos;
    logic                 pad_out;

    paddle_ctrl #(
        .NUM_CH(NUM_CH), .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST),
        .CENTER(CENTER), .ACCEL_FRAMES(ACCEL_FRAMES)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
        .pad_en_n(pad_en_n), .sel(sel), .mode(mode), .invert(invert), .speed(speed),
        .btn_left(btn_left), .btn_right(btn_right), .analog_x(analog_x),
        .analog_y(analog_y), .paddle(paddle), .pos(pos), .pad_out(pad_out)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference state: digital positions, line count, consecutive-hold frame run.
    int m_dig[NUM_CH];
    int m_cnt, m_run, m_dir, m_sel;
    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_pos(input int c);
        int md, v;
        md = int'(mode[2*c +: 2]);
        if (md == 0) return m_dig[c];
        if (md == 1)      v = int'($signed(analog_x[8*c +: 8])) + 128;
        else if (md == 2) v = int'($signed(analog_y[8*c +: 8])) + 128;
        else              v = int'(paddle[8*c +: 8]);
        return invert[c] ? v : 255 - v;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        foreach (m_dig[c]) m_dig[c] = CENTER;
        m_cnt = 0; m_run = 0; m_dir = -1; m_sel = -1;
    endtask

    task automatic check_pos(input string tag);
        for (int c = 0; c < NUM_CH; c++)
            chk(tag, int'(pos[8*c +: 8]), m_pos(c));
    endtask

    // One vsync rising edge with the currently driven buttons/sel/speed.
    task automatic frame(input string tag);
        int  s, step;
        bit  l, r, one, fast;
        s   = int'(sel);
        l   = btn_left[s];
        r   = btn_right[s];
        one = l ^ r;
        fast = 1'b0;
`ifdef PADDLE_CTRL_ACCEL_EN
        if (!one)                             m_run = 0;
        else if (m_run == 0)                  m_run = 1;
        else if (int'(l) == m_dir && s == m_sel) m_run++;
        else                                  m_run = 0;
        m_dir = int'(l);
        m_sel = s;
        fast  = (m_run >= ACCEL_FRAMES);
`endif
        step = (speed || fast) ? STEP_FAST : STEP_SLOW;
        if (r && !l) m_dig[s] = (m_dig[s] - step < 0) ? 0 : m_dig[s] - step;
        if (l && !r) m_dig[s] = (m_dig[s] + step > 255) ? 255 : m_dig[s] + step;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        check_pos(tag);
    endtask

    task automatic pad_clear();
        pad_en_n = 1'b0;
        tick();
        pad_en_n = 1'b1;
        m_cnt = 0;
    endtask

    task automatic hpulse(input string tag);
        hsync = 1'b1;
        tick();
        if (m_cnt < 255) m_cnt++;
        hsync = 1'b0;
        tick();
        chk(tag, int'(pad_out), int'(m_cnt < m_pos(int'(sel))));
    endtask

    initial begin
        do_reset();
        chk("rst_pos0", int'(pos[7:0]), 114);
        chk("rst_pos1", int'(pos[15:8]), 114);
        chk("rst_pad_out", int'(pad_out), 0);

        // Pot compare against the reset centre.
        pad_clear();
        tick();
        chk("pad_cnt0", int'(pad_out), 1);
        for (int i = 0; i < 116; i++) hpulse("pad_ramp");

        // Fast right on channel 0 down to the floor.
        sel = 1'b0; speed = 1'b1; btn_right = 2'b01;
        for (int i = 0; i < 30; i++) frame("right_fast");
        chk("right_floor", int'(pos[7:0]), 0);
        chk("ch1_hold", int'(pos[15:8]), 114);

        btn_left = 2'b01;
        for (int i = 0; i < 5; i++) frame("both_hold");
        chk("both_floor", int'(pos[7:0]), 0);

        do_reset();
        btn_right = '0; btn_left = 2'b01;
        for (int i = 0; i < 17; i++) frame("left_up");
        chk("left_250", int'(pos[7:0]), 250);
        frame("left_sat");
        chk("left_255", int'(pos[7:0]), 255);
        frame("left_sat2");

        // Stick conversion and inversion.
        btn_left = '0;
        mode = 4'b0001; analog_x[7:0] = 8'h80; invert = 2'b00; #1;
        chk("x80_inv0", int'(pos[7:0]), 255);
        invert = 2'b01; #1;
        chk("x80_inv1", int'(pos[7:0]), 0);
        analog_x[7:0] = 8'h7F; #1;
        chk("x7f_inv1", int'(pos[7:0]), 255);
        mode = 4'b0010; analog_y[7:0] = 8'h05; invert = 2'b00; #1;
        check_pos("y_mode");
        mode = '0; invert = '0;

        // Slow left hold: acceleration kicks in when enabled.
        do_reset();
        speed = 1'b0; sel = 1'b0; btn_left = 2'b01; btn_right = '0;
        for (int i = 0; i < 15; i++) frame("accel_slow");
        chk("accel_15", int'(pos[7:0]), 174);
        for (int i = 0; i < 5; i++) frame("accel_fast");
`ifdef PADDLE_CTRL_ACCEL_EN
        chk("accel_20", int'(pos[7:0]), 214);
`else
        chk("accel_20", int'(pos[7:0]), 194);
`endif
        btn_left = '0;
        frame("accel_release");
        btn_left = 2'b01;
        frame("accel_restart");
        chk("accel_restart_step", int'(pos[7:0]), m_dig[0]);

        // Reset while a direction is held, then a normal first update.
        for (int i = 0; i < 3; i++) frame("pre_reset");
        vsync = 1'b1; tick();
        do_reset();
        vsync = 1'b0; tick();
        frame("post_reset");
        chk("post_reset_118", int'(pos[7:0]), 118);

        // Randomised frames, sources and line compares.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            if ($urandom_range(0, 7) == 0) begin
                btn_left  = 2'($urandom);
                btn_right = 2'($urandom);
            end
            if ($urandom_range(0, 15) == 0) sel = 1'($urandom);
            if ($urandom_range(0, 5) == 0) speed = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                mode     = 4'($urandom);
                invert   = 2'($urandom);
                analog_x = 16'($urandom);
                analog_y = 16'($urandom);
                paddle   = 16'($urandom);
            end
            frame("rnd_frame");
            if ($urandom_range(0, 3) == 0) begin
                pad_clear();
                for (int k = 0; k < int'($urandom_range(1, 12)); k++) hpulse("rnd_pad");
            end
        end

        // Line counter saturation with a full-scale paddle.
        btn_left = '0; btn_right = '0;
        sel = 1'b0; mode = 4'b0011; invert = 2'b01; paddle[7:0] = 8'hFF;
        pad_clear();
        for (int i = 0; i < 300; i++) hpulse("sat_ramp");
        chk("sat_pad_out", int'(pad_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
